// File: rtl/pps_pkg.sv
// Shared types and constants for the PPS discipline blocks: state encodings,
// counter widths and a saturating increment helper.
package pps_pkg;

  typedef enum logic [1:0] {
    ST_ACQUIRE  = 2'b00,
    ST_QUALIFY  = 2'b01,
    ST_LOCKED   = 2'b10,
    ST_HOLDOVER = 2'b11
  } pps_state_e;

  localparam int PERIOD_100M = 100_000_000;
  localparam int INT_W = 28;
  localparam int LOC_W = 27;
  localparam int ERR_W = 28;
  localparam int CNT_W = 8;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pps_edge_sync.sv
// Two-flop synchroniser for an asynchronous PPS pin plus a registered
// one-cycle rising-edge pulse.
module pps_edge_sync (
  input  logic gclk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic [2:0] sr;

  always_ff @(posedge gclk) begin
    if (rst) begin
      sr   <= '0;
      rise <= 1'b0;
    end else begin
      sr   <= {sr[1:0], din};
      rise <= sr[1] & ~sr[2];
    end
  end

endmodule

// File: rtl/pps_sync_ctrl.sv
// Reference-PPS qualifier, lock tracker and phase-sync decision for the local
// PPS generator. Define PPS_SYNC_CTRL_FORCE_EN to add the i_force_sync input.
module pps_sync_ctrl
  import pps_pkg::*;
#(
  parameter int PERIOD    = PERIOD_100M,
  parameter int TOL       = 1000,
  parameter int QUAL_CNT  = 3,
  parameter int PHASE_THR = 100,
  parameter int HOLD_MAX  = 10
) (
  input  logic             i_clk,
  input  logic             i_res,
  input  logic             i_enable,
  input  logic             i_ref_pps,
  input  logic             i_local_pps,
`ifdef PPS_SYNC_CTRL_FORCE_EN
  input  logic             i_force_sync,
`endif
  output logic             o_ph_sync,
  output logic [1:0]       o_state,
  output logic             o_locked,
  output logic [ERR_W-1:0] o_phase_err,
  output logic             o_phase_err_vld,
  output logic [7:0]       o_resync_cnt
);

  localparam logic [INT_W-1:0] I_MIN  = INT_W'(PERIOD - TOL);
  localparam logic [INT_W-1:0] I_MAX  = INT_W'(PERIOD + TOL);
  localparam logic [INT_W-1:0] I_SAT  = INT_W'(PERIOD + TOL + 1);
  localparam logic [LOC_W-1:0] L_PER  = LOC_W'(PERIOD);
  localparam logic [LOC_W-1:0] L_HALF = LOC_W'(PERIOD / 2);
  localparam logic [LOC_W-1:0] T_LAST = LOC_W'(PERIOD - 1);
  localparam logic [ERR_W-1:0] THR    = ERR_W'(PHASE_THR);
  localparam logic [CNT_W-1:0] QCNT   = CNT_W'(QUAL_CNT);
  localparam logic [CNT_W-1:0] HMAX   = CNT_W'(HOLD_MAX);

  logic             ev, loc_q, lrise, tmo, i_ok, big, force_req, force_arm;
  logic [INT_W-1:0] r_int, ival;
  logic [LOC_W-1:0] r_loc, loc, tmr;
  logic [ERR_W-1:0] err, mag;
  logic [CNT_W-1:0] good_cnt, hold_cnt;
  pps_state_e       state;

  pps_edge_sync u_ref (.gclk(i_clk), .rst(i_res), .din(i_ref_pps), .rise(ev));

`ifdef PPS_SYNC_CTRL_FORCE_EN
  assign force_req = i_force_sync;
`else
  assign force_req = 1'b0;
`endif

  assign lrise = i_local_pps & ~loc_q;
  assign ival  = r_int + 1'b1;
  assign tmo   = (r_int == I_MAX) & ~ev;
  // A coincident timeout yields ival = I_MAX+1, so it is rejected here too.
  assign i_ok  = ev & (ival >= I_MIN) & (ival <= I_MAX);
  assign loc   = lrise ? '0 : r_loc;
  assign err   = (loc < L_HALF) ? ERR_W'(loc) : ERR_W'(loc) - ERR_W'(L_PER);
  assign mag   = err[ERR_W-1] ? -err : err;
  assign big   = (loc == L_PER) | (mag > THR);

  assign o_state  = state;
  assign o_locked = (state == ST_LOCKED);

  // r_loc reads as clocks elapsed since the last local rise, so a ref event
  // d clocks after the local rise sees err = +d.
  always_ff @(posedge i_clk) begin
    loc_q <= i_res ? 1'b0 : i_local_pps;
    if (i_res || !i_enable) begin
      r_int <= '0;
      r_loc <= '0;
    end else begin
      r_int <= ev ? '0 : (r_int == I_SAT) ? r_int : r_int + 1'b1;
      r_loc <= lrise ? LOC_W'(1) : (r_loc == L_PER) ? r_loc : r_loc + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_res) begin
      state           <= ST_ACQUIRE;
      good_cnt        <= '0;
      hold_cnt        <= '0;
      tmr             <= '0;
      force_arm       <= 1'b0;
      o_ph_sync       <= 1'b0;
      o_phase_err     <= '0;
      o_phase_err_vld <= 1'b0;
      o_resync_cnt    <= '0;
    end else begin
      o_ph_sync       <= 1'b0;
      o_phase_err_vld <= 1'b0;
      if (!i_enable) begin
        state     <= ST_ACQUIRE;
        good_cnt  <= '0;
        hold_cnt  <= '0;
        tmr       <= '0;
        force_arm <= 1'b0;
      end else begin
        case (state)
          ST_ACQUIRE: if (ev) begin
            state    <= ST_QUALIFY;
            good_cnt <= '0;
          end
          ST_QUALIFY: begin
            if (i_ok) begin
              if (good_cnt + 1'b1 == QCNT) begin
                state     <= ST_LOCKED;
                good_cnt  <= '0;
                o_ph_sync <= 1'b1;
              end else begin
                good_cnt <= good_cnt + 1'b1;
              end
            end else if (ev) begin
              good_cnt <= '0;
            end else if (tmo) begin
              state <= ST_ACQUIRE;
            end
          end
          ST_LOCKED: begin
            if (i_ok) begin
              o_phase_err     <= err;
              o_phase_err_vld <= 1'b1;
              if (big) begin
                o_ph_sync    <= 1'b1;
                o_resync_cnt <= sat_inc(o_resync_cnt);
              end
            end else if (ev) begin
              state    <= ST_QUALIFY;
              good_cnt <= '0;
            end else if (tmo) begin
              state    <= ST_HOLDOVER;
              hold_cnt <= CNT_W'(1);
              tmr      <= '0;
            end
          end
          ST_HOLDOVER: begin
            if (ev) begin
              o_phase_err     <= err;
              o_phase_err_vld <= 1'b1;
              state           <= big ? ST_QUALIFY : ST_LOCKED;
              good_cnt        <= '0;
            end else if (tmr == T_LAST) begin
              tmr      <= '0;
              hold_cnt <= hold_cnt + 1'b1;
              if (hold_cnt + 1'b1 == HMAX) state <= ST_ACQUIRE;
            end else begin
              tmr <= tmr + 1'b1;
            end
          end
        endcase
        // Forced alignment rides on the next event without touching state.
        if (ev && state != ST_ACQUIRE && force_arm) begin
          o_ph_sync <= 1'b1;
          force_arm <= 1'b0;
        end else if (force_req) begin
          force_arm <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pps_sync_ctrl.sv
// Scoreboard bench for pps_sync_ctrl with a 1000-clock period; local PPS
// rises on every multiple of 1000 cycles.
module tb_pps_sync_ctrl;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        enable = 1'b1;
  logic        ref_pps = 1'b0;
  logic        local_pps = 1'b0;
`ifdef PPS_SYNC_CTRL_FORCE_EN
  logic        force_sync = 1'b0;
`endif
  logic        ph_sync, locked, err_vld;
  logic [1:0]  state;
  logic [27:0] phase_err;
  logic [7:0]  resync_cnt;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    int          cyc;
    bit          sync;
    bit          vld;
    logic [27:0] err;
  } exp_t;
  exp_t sb[$];

  pps_sync_ctrl #(
    .PERIOD(1000), .TOL(10), .QUAL_CNT(3), .PHASE_THR(5), .HOLD_MAX(2)
  ) dut (
    .i_clk(clk),
    .i_res(res),
    .i_enable(enable),
    .i_ref_pps(ref_pps),
    .i_local_pps(local_pps),
`ifdef PPS_SYNC_CTRL_FORCE_EN
    .i_force_sync(force_sync),
`endif
    .o_ph_sync(ph_sync),
    .o_state(state),
    .o_locked(locked),
    .o_phase_err(phase_err),
    .o_phase_err_vld(err_vld),
    .o_resync_cnt(resync_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) local_pps = ((cyc + 1) % 1000 == 0);

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic wait_cyc(int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Expected phase error for an event consumed at edge e.
  function automatic int phase_of(int e);
    int r;
    r = e % 1000;
    return (r < 500) ? r : r - 1000;
  endfunction

  // Ref event consumed by the controller at edge e; outputs visible after it.
  task automatic ev_at(int e, bit s, bit v);
    exp_t x;
    x.cyc = e; x.sync = s; x.vld = v; x.err = 28'(phase_of(e));
    if (s || v) sb.push_back(x);
    wait_cyc(e - 4);
    ref_pps = 1'b1;
    wait_cyc(e);
    ref_pps = 1'b0;
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (ph_sync === 1'b1 || err_vld === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", {30'd0, ph_sync, err_vld}, 32'd0);
        end else begin
          x = sb.pop_front();
          chk("pulse_cycle", cyc, x.cyc);
          chk("ph_sync", {31'd0, ph_sync}, {31'd0, x.sync});
          chk("err_vld", {31'd0, err_vld}, {31'd0, x.vld});
          if (x.vld) chk("phase_err", {4'd0, phase_err}, {4'd0, x.err});
        end
      end
    end
  end

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: cycle %0d exceeded budget", cyc);
    $fatal(1);
  end

  initial begin
    wait_cyc(5);
    res = 1'b0;
    wait_cyc(6);
    chk("rst_state", state, 0);
    chk("rst_locked", locked, 0);
    chk("rst_resync", resync_cnt, 0);
    chk("rst_err", phase_err, 0);
    chk("rst_sync", ph_sync, 0);
    chk("rst_vld", err_vld, 0);

    // acquisition and lock
    ev_at(1000, 0, 0);  chk("acq_to_qual", state, 1);
    ev_at(2000, 0, 0);
    ev_at(3000, 0, 0);  chk("qual_3", state, 1);
    ev_at(4000, 1, 0);  chk("lock_state", state, 2);
    chk("lock_locked", locked, 1);
    chk("lock_resync", resync_cnt, 0);

    // phase steps while locked
    ev_at(5008, 1, 1);  chk("late8_resync", resync_cnt, 1);
    ev_at(6000, 0, 1);
    ev_at(6997, 0, 1);  chk("early3_resync", resync_cnt, 1);
    ev_at(8000, 0, 1);

    // interval boundaries
    ev_at(9011, 0, 0);  chk("i1011_state", state, 1);
    chk("i1011_locked", locked, 0);
    ev_at(10021, 0, 0);
    ev_at(11021, 0, 0); chk("i1010_qual", state, 1);
    ev_at(12021, 1, 0); chk("i1010_lock", state, 2);
    chk("relock_resync", resync_cnt, 1);
    ev_at(13021, 1, 1);
    ev_at(14011, 1, 1);
    ev_at(15002, 0, 1); chk("walk_resync", resync_cnt, 3);

    // holdover entry, recovery, expiry
    wait_cyc(16012);    chk("pre_timeout", state, 2);
    wait_cyc(16013);    chk("holdover", state, 3);
    ev_at(17003, 0, 1); chk("hold_relock", state, 2);
    chk("hold_resync", resync_cnt, 3);
    wait_cyc(18013);    chk("pre_timeout2", state, 2);
    wait_cyc(18014);    chk("holdover2", state, 3);
    wait_cyc(19013);    chk("hold_last", state, 3);
    wait_cyc(19014);    chk("hold_expire", state, 0);

    // disable mid-qualify
    ev_at(20000, 0, 0);
    ev_at(21000, 0, 0); chk("pre_dis", state, 1);
    wait_cyc(21500);
    enable = 1'b0;
    wait_cyc(21501);    chk("dis_state", state, 0);
    ev_at(22000, 0, 0); chk("dis_ev_state", state, 0);
    chk("dis_resync", resync_cnt, 3);
    wait_cyc(22500);
    enable = 1'b1;
    ev_at(23000, 0, 0); chk("reen_qual", state, 1);

    // reset mid-qualify
    wait_cyc(23500);
    res = 1'b1;
    wait_cyc(23502);
    res = 1'b0;
    chk("mrst_state", state, 0);
    chk("mrst_resync", resync_cnt, 0);
    chk("mrst_err", phase_err, 0);
    chk("mrst_locked", locked, 0);
    ev_at(24000, 0, 0); chk("mrst_qual", state, 1);

`ifdef PPS_SYNC_CTRL_FORCE_EN
    ev_at(25000, 0, 0);
    ev_at(26000, 0, 0);
    ev_at(27000, 1, 0);
    ev_at(28000, 0, 1);
    wait_cyc(28500);
    force_sync = 1'b1;
    wait_cyc(28501);
    force_sync = 1'b0;
    ev_at(29000, 1, 1); chk("force_resync", resync_cnt, 0);
    chk("force_state", state, 2);
`endif

    wait_cyc(cyc + 5);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
